ehl_ahb_slave_arb: RTL and testbench

- Per-slave-port arbiter for the AHB matrix output stage.
- Decides which of MNUM masters owns the slave address phase, and which master owns the data phase one pipeline stage later.
- Holds the grant across fixed-length bursts, undefined-length INCR bursts and HMASTLOCK sequences.
- Its one-hot grants drive the matrix output-stage address/control mux and the response routing.

---
 rtl/ehl_ahb_slave_arb.sv | 213 +++++++++++++++++++++
 tb/tb_ehl_ahb_slave_arb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ehl_ahb_slave_arb.sv
// AHB matrix per-slave-port arbiter: address-phase owner selection
// with burst / lock hold, plus the data-phase owner one stage later.
module ehl_ahb_slave_arb #(
   parameter int MNUM    = 8,
   parameter int DEF_MST = 0,
   localparam int IW     = $clog2(MNUM)
) (
   input  logic              hclk,
   input  logic              hreset,
   input  logic [MNUM-1:0]   req,
   input  logic [MNUM-1:0]   req_lock,
   input  logic [2*MNUM-1:0] req_trans,
   input  logic [3*MNUM-1:0] req_burst,
   input  logic              arb_type,
   input  logic              is_hready,
   output logic [MNUM-1:0]   addr_gnt,
   output logic [MNUM-1:0]   data_gnt,
   output logic [IW-1:0]     addr_idx,
   output logic              locked,
   output logic              burst
);

   localparam logic [1:0] HT_IDLE   = 2'b00;
   localparam logic [1:0] HT_BUSY   = 2'b01;
   localparam logic [1:0] HT_NONSEQ = 2'b10;
   localparam logic [1:0] HT_SEQ    = 2'b11;

   localparam logic [2:0] HB_SINGLE = 3'd0;
   localparam logic [2:0] HB_INCR   = 3'd1;
   localparam logic [2:0] HB_WRAP4  = 3'd2;
   localparam logic [2:0] HB_INCR4  = 3'd3;
   localparam logic [2:0] HB_WRAP8  = 3'd4;
   localparam logic [2:0] HB_INCR8  = 3'd5;
   localparam logic [2:0] HB_WRAP16 = 3'd6;
   localparam logic [2:0] HB_INCR16 = 3'd7;

   localparam logic [IW-1:0]   DEF_IDX = IW'(DEF_MST);
   localparam logic [MNUM-1:0] ONE     = {{(MNUM-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_ARB,
      ST_BURST,
      ST_LOCK
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            undef_q, undef_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [MNUM-1:0] agnt_q, agnt_d;
   logic [MNUM-1:0] dgnt_q, dgnt_d;
   logic            locked_q, locked_d;
   logic            burst_q, burst_d;

   logic [1:0]      t;
   logic [2:0]      b;
   logic            lk;
   logic [3:0]      beats_m1;
   logic [IW-1:0]   rr_win;
   logic [IW-1:0]   fp_win;
   logic            do_eval;
   logic            do_rearb;

   // Round-robin: first requester after the pointer, wrapping.
   function automatic logic [IW-1:0] rr_pick(
      input logic [MNUM-1:0] r,
      input logic [IW-1:0]   p
   );
      logic [IW-1:0] w;
      logic [IW-1:0] ji;
      int            j;
      w = p;
      for (int k = MNUM; k >= 1; k--) begin
         j  = (int'(p) + k) % MNUM;
         ji = IW'(j);
         if (r[ji]) w = ji;
      end
      return w;
   endfunction

   // Fixed priority: lowest set index wins.
   function automatic logic [IW-1:0] fp_pick(
      input logic [MNUM-1:0] r,
      input logic [IW-1:0]   p
   );
      logic [IW-1:0] w;
      logic [IW-1:0] ii;
      w = p;
      for (int i = MNUM - 1; i >= 0; i--) begin
         ii = IW'(i);
         if (r[ii]) w = ii;
      end
      return w;
   endfunction

   // Select the current owner's HTRANS / HBURST / HMASTLOCK.
   always_comb begin
      t  = HT_IDLE;
      b  = HB_SINGLE;
      lk = 1'b0;
      for (int i = 0; i < MNUM; i++) begin
         if (idx_q == IW'(i)) begin
            t  = req_trans[2*i +: 2];
            b  = req_burst[3*i +: 3];
            lk = req_lock[i];
         end
      end
   end

   // Burst length minus one for the beat counter.
   always_comb begin
      unique case (b)
         HB_WRAP4,  HB_INCR4:  beats_m1 = 4'd3;
         HB_WRAP8,  HB_INCR8:  beats_m1 = 4'd7;
         HB_WRAP16, HB_INCR16: beats_m1 = 4'd15;
         default:              beats_m1 = 4'd0;
      endcase
   end

   assign rr_win = rr_pick(req, ptr_q);
   assign fp_win = fp_pick(req, idx_q);

   // Next-state: hold on stalls, otherwise walk ARB/BURST/LOCK.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      undef_d  = undef_q;
      idx_d    = idx_q;
      ptr_d    = ptr_q;
      dgnt_d   = dgnt_q;
      do_eval  = 1'b0;
      do_rearb = 1'b0;
      if (is_hready) begin
         if (t == HT_NONSEQ || t == HT_SEQ) dgnt_d = agnt_q;
         else                               dgnt_d = '0;
         unique case (state_q)
            ST_ARB: do_eval = 1'b1;
            ST_BURST: begin
               if (t == HT_SEQ && !undef_q) begin
                  cnt_d = cnt_q - 4'd1;
                  if (cnt_q == 4'd1) do_rearb = 1'b1;
               end else if (t == HT_IDLE || t == HT_NONSEQ) begin
                  do_eval = 1'b1;
               end
            end
            ST_LOCK: if (!lk) do_eval = 1'b1;
            default: do_eval = 1'b1;
         endcase
         if (do_eval) begin
            if (t == HT_NONSEQ && lk) begin
               state_d = ST_LOCK;
               cnt_d   = 4'd0;
               undef_d = 1'b0;
            end else if (t == HT_NONSEQ && b != HB_SINGLE) begin
               state_d = ST_BURST;
               cnt_d   = beats_m1;
               undef_d = (b == HB_INCR);
            end else begin
               do_rearb = 1'b1;
            end
         end
         if (do_rearb) begin
            state_d = ST_ARB;
            cnt_d   = 4'd0;
            undef_d = 1'b0;
            if (|req) begin
               if (arb_type) begin
                  idx_d = fp_win;
               end else begin
                  idx_d = rr_win;
                  ptr_d = rr_win;
               end
            end
         end
      end
      agnt_d   = ONE << idx_d;
      locked_d = (state_d == ST_LOCK);
      burst_d  = (state_d == ST_BURST);
   end

   // State and registered outputs.
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state_q  <= ST_ARB;
         cnt_q    <= 4'd0;
         undef_q  <= 1'b0;
         idx_q    <= DEF_IDX;
         ptr_q    <= DEF_IDX;
         agnt_q   <= ONE << DEF_IDX;
         dgnt_q   <= '0;
         locked_q <= 1'b0;
         burst_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         undef_q  <= undef_d;
         idx_q    <= idx_d;
         ptr_q    <= ptr_d;
         agnt_q   <= agnt_d;
         dgnt_q   <= dgnt_d;
         locked_q <= locked_d;
         burst_q  <= burst_d;
      end
   end

   assign addr_gnt = agnt_q;
   assign data_gnt = dgnt_q;
   assign addr_idx = idx_q;
   assign locked   = locked_q;
   assign burst    = burst_q;

endmodule

// File: tb/tb_ehl_ahb_slave_arb.sv
// Directed bench for ehl_ahb_slave_arb (MNUM=8, DEF_MST=0):
// parking, round-robin, fixed priority, bursts, early stop, lock.
module tb_ehl_ahb_slave_arb;

   localparam int MNUM = 8;
   localparam int IW   = 3;

   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] BUSY   = 2'b01;
   localparam logic [1:0] NONSEQ = 2'b10;
   localparam logic [1:0] SEQ    = 2'b11;
   localparam logic [2:0] SINGLE = 3'd0;
   localparam logic [2:0] INCR4  = 3'd3;
   localparam logic [2:0] INCR8  = 3'd5;

   logic              hclk;
   logic              hreset;
   logic [MNUM-1:0]   req;
   logic [MNUM-1:0]   req_lock;
   logic [2*MNUM-1:0] req_trans;
   logic [3*MNUM-1:0] req_burst;
   logic              arb_type;
   logic              is_hready;
   logic [MNUM-1:0]   addr_gnt;
   logic [MNUM-1:0]   data_gnt;
   logic [IW-1:0]     addr_idx;
   logic              locked;
   logic              burst;

   int n_chk;
   int n_fail;

   ehl_ahb_slave_arb #(.MNUM(MNUM), .DEF_MST(0)) dut (
      .hclk      (hclk),
      .hreset    (hreset),
      .req       (req),
      .req_lock  (req_lock),
      .req_trans (req_trans),
      .req_burst (req_burst),
      .arb_type  (arb_type),
      .is_hready (is_hready),
      .addr_gnt  (addr_gnt),
      .data_gnt  (data_gnt),
      .addr_idx  (addr_idx),
      .locked    (locked),
      .burst     (burst)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Every master drives the same HTRANS/HBURST; only the owner's matter.
   task automatic step(input logic hr, input logic [1:0] tr,
                       input logic [2:0] bu);
      is_hready = hr;
      req_trans = {MNUM{tr}};
      req_burst = {MNUM{bu}};
      @(posedge hclk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge hclk);
      #1;
      hreset = 1'b1;
      #2;
      hreset = 1'b0;
   endtask

   initial begin
      n_chk     = 0;
      n_fail    = 0;
      hreset    = 1'b1;
      req       = '0;
      req_lock  = '0;
      req_trans = '0;
      req_burst = '0;
      arb_type  = 1'b0;
      is_hready = 1'b1;
      #12;
      hreset = 1'b0;

      check("rst_agnt", 32'(addr_gnt), 32'h01);
      check("rst_dgnt", 32'(data_gnt), 32'h00);
      check("rst_idx",  32'(addr_idx), 32'h0);
      check("rst_lock", 32'(locked),   32'h0);
      check("rst_brst", 32'(burst),    32'h0);

      // Park on master 0 with no requests.
      for (int i = 0; i < 5; i++) begin
         step(1'b1, IDLE, SINGLE);
         check("park_agnt", 32'(addr_gnt), 32'h01);
         check("park_dgnt", 32'(data_gnt), 32'h00);
      end
      req = 8'h04;
      step(1'b1, IDLE, SINGLE);
      check("req4_agnt", 32'(addr_gnt), 32'h04);
      check("req4_idx",  32'(addr_idx), 32'h2);

      // Round-robin over masters 0,1,3 with NONSEQ SINGLE.
      do_reset();
      req = 8'h0B;
      step(1'b1, NONSEQ, SINGLE);
      check("rr1_agnt", 32'(addr_gnt), 32'h02);
      check("rr1_dgnt", 32'(data_gnt), 32'h01);
      step(1'b1, NONSEQ, SINGLE);
      check("rr2_agnt", 32'(addr_gnt), 32'h08);
      check("rr2_dgnt", 32'(data_gnt), 32'h02);
      step(1'b1, NONSEQ, SINGLE);
      check("rr3_agnt", 32'(addr_gnt), 32'h01);
      check("rr3_dgnt", 32'(data_gnt), 32'h08);
      // Stall with changed req: nothing moves.
      req = 8'h40;
      step(1'b0, NONSEQ, SINGLE);
      check("rrst_agnt", 32'(addr_gnt), 32'h01);
      check("rrst_dgnt", 32'(data_gnt), 32'h08);

      // Fixed priority: master 1 beats master 2 every time.
      do_reset();
      arb_type = 1'b1;
      req      = 8'h06;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, NONSEQ, SINGLE);
         check("fp_agnt", 32'(addr_gnt), 32'h02);
      end
      arb_type = 1'b0;

      // INCR8 from master 2 with BUSY and stalls in the middle.
      do_reset();
      req = 8'h04;
      step(1'b1, IDLE, SINGLE);
      check("b8_own", 32'(addr_gnt), 32'h04);
      req = 8'hFF;
      step(1'b1, NONSEQ, INCR8);
      check("b8_brst", 32'(burst),    32'h1);
      check("b8_agnt", 32'(addr_gnt), 32'h04);
      check("b8_dgnt", 32'(data_gnt), 32'h04);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, SEQ, INCR8);
         check("b8_seqa", 32'(addr_gnt), 32'h04);
      end
      for (int i = 0; i < 2; i++) begin
         step(1'b1, BUSY, INCR8);
         check("b8_busy_agnt", 32'(addr_gnt), 32'h04);
         check("b8_busy_dgnt", 32'(data_gnt), 32'h00);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, SEQ, INCR8);
         check("b8_stall", 32'(addr_gnt), 32'h04);
      end
      check("b8_stall_dgnt", 32'(data_gnt), 32'h00);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, SEQ, INCR8);
         check("b8_seqb", 32'(addr_gnt), 32'h04);
         check("b8_seqb_brst", 32'(burst), 32'h1);
      end
      step(1'b1, SEQ, INCR8);
      check("b8_end_agnt", 32'(addr_gnt), 32'h08);
      check("b8_end_dgnt", 32'(data_gnt), 32'h04);
      check("b8_end_brst", 32'(burst),    32'h0);

      // INCR4 from master 5 terminated by IDLE after beat 2.
      do_reset();
      req = 8'h20;
      step(1'b1, IDLE, SINGLE);
      check("b4_own", 32'(addr_gnt), 32'h20);
      req = 8'hFF;
      step(1'b1, NONSEQ, INCR4);
      check("b4_brst", 32'(burst), 32'h1);
      step(1'b1, SEQ, INCR4);
      check("b4_seq", 32'(addr_gnt), 32'h20);
      step(1'b1, IDLE, INCR4);
      check("b4_idle_agnt", 32'(addr_gnt), 32'h40);
      check("b4_idle_dgnt", 32'(data_gnt), 32'h00);
      check("b4_idle_brst", 32'(burst),    32'h0);

      // Master 1 lock sequence, release, relock and async reset.
      do_reset();
      req = 8'h02;
      step(1'b1, IDLE, SINGLE);
      check("lk_own", 32'(addr_gnt), 32'h02);
      req      = 8'hFF;
      req_lock = 8'h02;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, NONSEQ, SINGLE);
         check("lk_lock", 32'(locked),   32'h1);
         check("lk_agnt", 32'(addr_gnt), 32'h02);
         check("lk_dgnt", 32'(data_gnt), 32'h02);
      end
      req_lock = 8'h00;
      step(1'b1, NONSEQ, SINGLE);
      check("lk_rel_agnt", 32'(addr_gnt), 32'h04);
      check("lk_rel_lock", 32'(locked),   32'h0);
      req_lock = 8'h04;
      step(1'b1, NONSEQ, SINGLE);
      check("lk2_lock", 32'(locked),   32'h1);
      check("lk2_agnt", 32'(addr_gnt), 32'h04);
      hreset = 1'b1;
      #1;
      check("arst_agnt", 32'(addr_gnt), 32'h01);
      check("arst_dgnt", 32'(data_gnt), 32'h00);
      check("arst_idx",  32'(addr_idx), 32'h0);
      check("arst_lock", 32'(locked),   32'h0);
      check("arst_brst", 32'(burst),    32'h0);
      #2;
      hreset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
